dmem_bytelane: RTL and testbench

- Parametrised, single-port, byte-addressed, little-endian data memory for the CNN datapath/load-store unit.
- Successor to the fixed 32-bit word-only data memory. Adds byte/half/word/double access sizes, sign or zero extension, and a registered read with a valid flag.
- Adds misalignment error reporting, a req/ready handshake and an optional zero-clear sweep after reset.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_load_align.sv | 44 ++++
 rtl/dmem_bytelane.sv | 125 ++++++++++++
 tb/tb_dmem_bytelane.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane-enable helper for the byte-lane data memory.
package dmem_pkg;

    localparam int unsigned MAX_NB = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Byte enables for an access of the given size starting at lane offset.
    function automatic logic [MAX_NB-1:0] lane_mask(input size_e sz, input logic [2:0] offset);
        logic [MAX_NB-1:0] base;
        case (sz)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extracts the addressed lanes of a memory word and sign/zero-extends them.
module dmem_load_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFS_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] word_in,
    input  logic [OFS_W-1:0]  offset,
    input  size_e             size,
    input  logic              unsigned_ld,
    output logic [DATA_W-1:0] rdata_next
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] low_mask;
    logic              sign;

    always_comb begin
        shifted  = word_in >> {offset, 3'b000};
        low_mask = '1;
        sign     = 1'b0;
        case (size)
            SZ_B: begin
                low_mask = DATA_W'(8'hFF);
                sign     = shifted[7] & ~unsigned_ld;
            end
            SZ_H: begin
                low_mask = DATA_W'(16'hFFFF);
                sign     = shifted[15] & ~unsigned_ld;
            end
            SZ_W: begin
                low_mask = DATA_W'(32'hFFFF_FFFF);
                sign     = shifted[31] & ~unsigned_ld;
            end
            default: begin
                low_mask = '1;
                sign     = 1'b0;
            end
        endcase
        rdata_next = (shifted & low_mask) | (sign ? ~low_mask : '0);
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Single-port byte-addressed little-endian data memory with sized loads/stores,
// registered read, misalignment reporting and an optional post-reset zero sweep.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned OFS_W  = $clog2(NB);
    localparam int unsigned WORD_W = ADDR_W - OFS_W;
    localparam int unsigned WORDS  = 2 ** WORD_W;

    logic [DATA_W-1:0] mem [WORDS];

    state_e              state;
    logic [WORD_W-1:0]   clr_cnt;
    size_e               sz_c;
    logic [OFS_W-1:0]    offset_c;
    logic [WORD_W-1:0]   widx_c;
    logic                legal_c;
    logic                accept_c;
    logic                st_we_c;
    logic                clr_we_c;
    logic [MAX_NB-1:0]   be_c;
    logic [DATA_W-1:0]   wdata_sh_c;
    logic [DATA_W-1:0]   rdata_next_c;
    logic                unused_c;

    assign sz_c       = size_e'(size);
    assign offset_c   = addr[OFS_W-1:0];
    assign widx_c     = addr[ADDR_W-1:OFS_W];
    assign accept_c   = req & ready;
    assign st_we_c    = accept_c & we & legal_c;
    // Gate with rst_n so a held reset never writes the array.
    assign clr_we_c   = (state == CLEAR) & rst_n;
    assign be_c       = lane_mask(sz_c, 3'(offset_c));
    assign wdata_sh_c = wdata << {offset_c, 3'b000};
    assign unused_c   = ^be_c;

    always_comb begin
        legal_c = 1'b0;
        case (sz_c)
            SZ_B: legal_c = 1'b1;
            SZ_H: legal_c = ~addr[0];
            SZ_W: legal_c = (addr[1:0] == 2'b00);
            SZ_D: legal_c = (DATA_W == 32'd64) && (addr[2:0] == 3'b000);
            default: legal_c = 1'b0;
        endcase
    end

    dmem_load_align #(
        .DATA_W (DATA_W),
        .OFS_W  (OFS_W)
    ) u_align (
        .word_in     (mem[widx_c]),
        .offset      (offset_c),
        .size        (sz_c),
        .unsigned_ld (unsigned_ld),
        .rdata_next  (rdata_next_c)
    );

    // Storage array: clear sweep or byte-enabled store.
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_cnt] <= '0;
        end else if (st_we_c) begin
            for (int b = 0; b < NB; b++) begin
                if (be_c[b]) begin
                    mem[widx_c][8*b +: 8] <= wdata_sh_c[8*b +: 8];
                end
            end
        end
    end

    // Control FSM and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt <= '0;
            ready   <= 1'b0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    if (accept_c) begin
                        rvalid <= ~we;
                        err    <= ~legal_c;
                        if (!we && legal_c) begin
                            rdata <= rdata_next_c;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Randomised scoreboard bench for dmem_bytelane against a byte-array reference model.
module tb_dmem_bytelane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, unsigned_ld;
    logic [9:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        ready, rvalid, err;
    logic [31:0] rdata;

    logic        req64, we64, uns64;
    logic [5:0]  addr64;
    logic [1:0]  size64;
    logic [63:0] wdata64;
    logic        ready64, rvalid64, err64;
    logic [63:0] rdata64;

    always #5 clk = ~clk;

    dmem_bytelane #(.DATA_W(32), .ADDR_W(10), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .size(size),
        .unsigned_ld(unsigned_ld), .wdata(wdata), .ready(ready), .rvalid(rvalid),
        .rdata(rdata), .err(err)
    );

    dmem_bytelane #(.DATA_W(64), .ADDR_W(6), .CLEAR_ON_RESET(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .req(req64), .we(we64), .addr(addr64), .size(size64),
        .unsigned_ld(uns64), .wdata(wdata64), .ready(ready64), .rvalid(rvalid64),
        .rdata(rdata64), .err(err64)
    );

    typedef struct {
        logic        rv;
        logic        er;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [1024];
    logic [31:0] last_rd;
    int          checks = 0;
    int          errors = 0;
    int          streak = 0;
    int          max_streak = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        last_rd = 32'h0;
        exp_q.delete();
    endtask

    // Drive one request for one clock and record the model's expected response.
    task automatic issue(input bit w, input int a, input int sz, input bit uns, input logic [31:0] wd);
        int          nbytes;
        bit          legal;
        logic [63:0] v;
        exp_t        e;
        @(negedge clk);
        req = 1'b1; we = w; addr = 10'(a); size = 2'(sz); unsigned_ld = uns; wdata = wd;
        nbytes = 1 << sz;
        legal  = (sz != 3) && ((a % nbytes) == 0);
        if (!legal) begin
            e.rv = !w; e.er = 1'b1; e.data = last_rd;
            exp_q.push_back(e);
        end else if (w) begin
            for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
            v = 64'h0;
            for (int i = 0; i < nbytes; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
            if (!uns && v[8*nbytes-1]) v = v | ~((64'd1 << (8 * nbytes)) - 64'd1);
            last_rd = v[31:0];
            e.rv = 1'b1; e.er = 1'b0; e.data = last_rd;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int cnt = 0;
        while (!ready && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk(name, 64'(cnt), 64'(exp_cycles));
    endtask

    // Monitor: pop one expectation per presented response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rvalid) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
            end else begin
                streak = 0;
            end
            if (rvalid || err) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_response rvalid=%b err=%b rdata=%h", rvalid, err, rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rvalid !== e.rv || err !== e.er || rdata !== e.data) begin
                        errors++;
                        $display("FAIL response rvalid=%b err=%b rdata=%h required rvalid=%b err=%b rdata=%h",
                                 rvalid, err, rdata, e.rv, e.er, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int a, sz, nb;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; size = '0; unsigned_ld = 1'b0; wdata = '0;
        req64 = 1'b0; we64 = 1'b0; uns64 = 1'b0; addr64 = '0; size64 = '0; wdata64 = '0;
        model_reset();
        #12;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("clear_cycles", 256);

        issue(0, 10'h3FC, 2, 0, 0);
        issue(1, 10'h010, 2, 0, 32'h8081_7F01);
        issue(0, 10'h010, 0, 0, 0);
        issue(0, 10'h011, 0, 0, 0);
        issue(0, 10'h012, 0, 0, 0);
        issue(0, 10'h013, 0, 0, 0);
        issue(0, 10'h013, 0, 1, 0);
        issue(1, 10'h020, 2, 0, 32'h1122_3344);
        issue(1, 10'h022, 1, 0, 32'h0000_BEEF);
        issue(0, 10'h020, 2, 0, 0);
        issue(0, 10'h022, 1, 0, 0);
        issue(0, 10'h006, 2, 0, 0);
        issue(1, 10'h001, 1, 0, 32'h0000_FFFF);
        issue(0, 10'h000, 2, 1, 0);
        issue(0, 10'h004, 3, 0, 0);
        issue(1, 10'h008, 3, 0, 32'h1234_5678);
        idle(1);
        issue(1, 10'h040, 2, 0, 32'hCAFE_F00D);
        issue(0, 10'h040, 2, 0, 0);
        idle(3);
        max_streak = 0;
        issue(0, 10'h010, 2, 0, 0);
        issue(0, 10'h020, 2, 1, 0);
        issue(0, 10'h040, 1, 0, 0);
        issue(0, 10'h012, 1, 1, 0);
        idle(3);
        chk("b2b_rvalid_pulses", 64'(max_streak), 64'd4);

        for (int i = 0; i < 300; i++) begin
            sz = int'($urandom_range(0, 3));
            nb = 1 << sz;
            a  = 32'h100 + int'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) a = a & ~(nb - 1);
            issue(bit'($urandom_range(0, 1)), a, sz, bit'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        // 64-bit instance: double round-trip and word extraction.
        @(negedge clk);
        chk("w64_ready", 64'(ready64), 64'd1);
        req64 = 1'b1; we64 = 1'b1; addr64 = 6'h08; size64 = 2'b11; wdata64 = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        we64 = 1'b0;
        @(negedge clk);
        chk("w64_dbl_rvalid", 64'(rvalid64), 64'd1);
        chk("w64_dbl_rdata", rdata64, 64'h0123_4567_89AB_CDEF);
        size64 = 2'b10; uns64 = 1'b0;
        @(negedge clk);
        chk("w64_word_signed", rdata64, 64'hFFFF_FFFF_89AB_CDEF);
        addr64 = 6'h0C; uns64 = 1'b1;
        @(negedge clk);
        chk("w64_word_hi", rdata64, 64'h0000_0000_0123_4567);
        addr64 = 6'h04; size64 = 2'b11;
        @(negedge clk);
        chk("w64_misaligned_err", 64'(err64), 64'd1);
        chk("w64_misaligned_rdata", rdata64, 64'h0000_0000_0123_4567);
        req64 = 1'b0;
        @(negedge clk);
        chk("w64_idle_quiet", 64'({rvalid64, err64}), 64'd0);

        // Reset during RUN, then again mid-clear.
        issue(1, 10'h200, 2, 0, 32'hDEAD_BEEF);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        chk("midclear_ready", 64'(ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midclear_rst_ready", 64'(ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reclear_cycles", 256);
        issue(0, 10'h200, 2, 0, 0);
        issue(0, 10'h3FC, 2, 0, 0);
        idle(3);
        chk("final_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
